// File: rtl/multicycle_core.sv
// multicycle_core
// Multi-cycle RV32-style integer core: add/sub/and/or/mul/addi, fetched one
// word at a time over a req/ack instruction port. mul uses an iterative
// shift-add unit that runs for exactly XLEN cycles.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   start_i      level; leaves IDLE when high (ignored elsewhere)
//   imem_req_o   fetch request, high for the whole FETCH state
//   imem_addr_o  fetch byte address (= PC)
//   imem_ack_i   fetch data valid this cycle (only honoured in FETCH)
//   imem_data_i  instruction word
//   busy_o       high in every state except IDLE and HALT
//   halt_o       high in HALT
//   pc_o         current PC
//   wb_en_o      one-cycle pulse per register write
//   wb_addr_o    index of the register written (zero-extended)
//   wb_data_o    value written
module multicycle_core #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int PC_W     = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic            busy_o,
    output logic            halt_o,
    output logic [PC_W-1:0] pc_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o
);
    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MUL, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL
    } op_t;

    state_t state_reg, state_next;

    logic [31:0]       instr_reg;
    op_t               op_reg;
    logic [RIDX_W-1:0] rd_reg;
    // op_a/op_b double as the multiplicand/multiplier shift registers in MUL,
    // and result_reg is the accumulator there.
    logic [XLEN-1:0]   op_a_reg;
    logic [XLEN-1:0]   op_b_reg;
    logic [XLEN-1:0]   result_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [XLEN-1:0]   regs [NUM_REGS];

    // ---------------- decode ----------------
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [RIDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]   rs1_val, rs2_val, imm_sext;
    op_t               op_dec;
    logic              use_imm;
    logic              wb_write;

    assign opcode  = instr_reg[6:0];
    assign funct3  = instr_reg[14:12];
    assign funct7  = instr_reg[31:25];
    assign rd_idx  = instr_reg[7 +: RIDX_W];
    assign rs1_idx = instr_reg[15 +: RIDX_W];
    assign rs2_idx = instr_reg[20 +: RIDX_W];
    assign rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];

    // Sign-extend (or truncate, for XLEN < 12) the I-type immediate.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_imm
        if (gi < 12) begin : g_low
            assign imm_sext[gi] = instr_reg[20+gi];
        end else begin : g_ext
            assign imm_sext[gi] = instr_reg[31];
        end
    end

    always_comb begin
        op_dec  = OP_NOP;
        use_imm = 1'b0;
        if (opcode == 7'b0110011) begin
            case ({funct7, funct3})
                10'b0000000_000: op_dec = OP_ADD;
                10'b0100000_000: op_dec = OP_SUB;
                10'b0000000_111: op_dec = OP_AND;
                10'b0000000_110: op_dec = OP_OR;
                10'b0000001_000: op_dec = OP_MUL;
                default:         op_dec = OP_NOP;
            endcase
        end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
            // addi is an add whose second operand is the immediate
            op_dec  = OP_ADD;
            use_imm = 1'b1;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start_i) state_next = S_FETCH;
            S_FETCH:  if (imem_ack_i) state_next = S_DECODE;
            S_DECODE: state_next = (instr_reg == 32'h0) ? S_HALT : S_EXEC;
            S_EXEC:   state_next = (op_reg == OP_MUL) ? S_MUL : S_WB;
            S_MUL:    if (cnt_reg == CNT_W'(XLEN - 1)) state_next = S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_reg     <= '0;
            instr_reg  <= '0;
            op_reg     <= OP_NOP;
            rd_reg     <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (imem_ack_i) instr_reg <= imem_data_i;
                end
                S_DECODE: begin
                    op_reg   <= op_dec;
                    rd_reg   <= rd_idx;
                    op_a_reg <= rs1_val;
                    op_b_reg <= use_imm ? imm_sext : rs2_val;
                end
                S_EXEC: begin
                    cnt_reg <= '0;
                    case (op_reg)
                        OP_ADD:  result_reg <= op_a_reg + op_b_reg;
                        OP_SUB:  result_reg <= op_a_reg - op_b_reg;
                        OP_AND:  result_reg <= op_a_reg & op_b_reg;
                        OP_OR:   result_reg <= op_a_reg | op_b_reg;
                        default: result_reg <= '0;
                    endcase
                end
                S_MUL: begin
                    // One multiplier bit per cycle, LSB first.
                    if (op_b_reg[0]) result_reg <= result_reg + op_a_reg;
                    op_a_reg <= op_a_reg << 1;
                    op_b_reg <= op_b_reg >> 1;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                end
                S_WB: begin
                    pc_reg <= pc_reg + PC_W'(4);
                end
                default: ;
            endcase
        end
    end

    // ---------------- register file ----------------
    assign wb_write = (state_reg == S_WB) && (op_reg != OP_NOP) && (rd_reg != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[rd_reg] <= result_reg;
        end
    end

    // ---------------- outputs ----------------
    assign imem_req_o  = (state_reg == S_FETCH);
    assign imem_addr_o = pc_reg;
    assign busy_o      = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign halt_o      = (state_reg == S_HALT);
    assign pc_o        = pc_reg;
    assign wb_en_o     = wb_write;
    assign wb_addr_o   = wb_write ? 5'(rd_reg) : 5'd0;
    assign wb_data_o   = wb_write ? result_reg : '0;

endmodule
